// File: rtl/cache_mem_arbiter_if.sv
// Bus bundle between the two L1 miss controllers, the arbiter and the shared L2/memory port.
// slave = arbiter view; master = environment view (caches plus downstream memory).
interface cache_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
);
    logic              i_read;
    logic [ADDR_W-1:0] i_addr;
    logic [LINE_W-1:0] i_rdata;
    logic              i_resp;

    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_addr;
    logic [LINE_W-1:0] d_wdata;
    logic [LINE_W-1:0] d_rdata;
    logic              d_resp;

    logic              m_read;
    logic              m_write;
    logic [ADDR_W-1:0] m_addr;
    logic [LINE_W-1:0] m_wdata;
    logic [LINE_W-1:0] m_rdata;
    logic              m_resp;

    modport slave (
        input  i_read, i_addr, d_read, d_write, d_addr, d_wdata, m_rdata, m_resp,
        output i_rdata, i_resp, d_rdata, d_resp, m_read, m_write, m_addr, m_wdata
    );

    modport master (
        output i_read, i_addr, d_read, d_write, d_addr, d_wdata, m_rdata, m_resp,
        input  i_rdata, i_resp, d_rdata, d_resp, m_read, m_write, m_addr, m_wdata
    );
endinterface

// File: rtl/cache_mem_arbiter.sv
// Serialises icache line reads and dcache reads/write-backs onto one line-wide memory port,
// with fixed (dcache-first) or round-robin conflict resolution and a saturating conflict counter.
module cache_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256,
    parameter int RR_EN  = 0,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    cache_mem_arbiter_if.slave bus,
    output logic [CNT_W-1:0] conflict_count
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_BUSY_I  = 2'd1,
        S_BUSY_D  = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_last_d;      // 1: most recent grant went to dcache
    logic [CNT_W-1:0] r_conflict;

    logic              w_i_req;
    logic              w_d_req;
    logic              w_conflict;
    logic              w_pick_i;
    logic              w_m_read;
    logic              w_m_write;
    logic [ADDR_W-1:0] w_m_addr;
    logic [LINE_W-1:0] w_m_wdata;
    logic              w_i_resp;
    logic              w_d_resp;

    assign w_i_req    = bus.i_read;
    assign w_d_req    = bus.d_read | bus.d_write;
    assign w_conflict = w_i_req & w_d_req;
    // Round-robin hands a conflict to icache only when dcache won last time.
    assign w_pick_i   = (RR_EN != 0) && r_last_d;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_conflict)   w_state_nxt = w_pick_i ? S_BUSY_I : S_BUSY_D;
                else if (w_i_req) w_state_nxt = S_BUSY_I;
                else if (w_d_req) w_state_nxt = S_BUSY_D;
            end
            S_BUSY_I,
            S_BUSY_D: begin
                if (bus.m_resp) w_state_nxt = S_RELEASE;
            end
            S_RELEASE: w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_last_d <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_IDLE && w_state_nxt == S_BUSY_I) r_last_d <= 1'b0;
            if (r_state == S_IDLE && w_state_nxt == S_BUSY_D) r_last_d <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_conflict <= '0;
        end else if (r_state == S_IDLE && w_conflict && r_conflict != {CNT_W{1'b1}}) begin
            r_conflict <= r_conflict + 1'b1;
        end
    end

    // Downstream mux follows the registered grant; requester fields are held stable meanwhile.
    always_comb begin
        w_m_read  = 1'b0;
        w_m_write = 1'b0;
        w_m_addr  = '0;
        w_m_wdata = '0;
        w_i_resp  = 1'b0;
        w_d_resp  = 1'b0;
        case (r_state)
            S_BUSY_I: begin
                w_m_read = 1'b1;
                w_m_addr = bus.i_addr;
                w_i_resp = bus.m_resp;
            end
            S_BUSY_D: begin
                w_m_write = bus.d_write;
                w_m_read  = ~bus.d_write;
                w_m_addr  = bus.d_addr;
                w_m_wdata = bus.d_wdata;
                w_d_resp  = bus.m_resp;
            end
            default: ;
        endcase
    end

    assign bus.m_read      = w_m_read;
    assign bus.m_write     = w_m_write;
    assign bus.m_addr      = w_m_addr;
    assign bus.m_wdata     = w_m_wdata;
    assign bus.i_resp      = w_i_resp;
    assign bus.d_resp      = w_d_resp;
    assign bus.i_rdata     = bus.m_rdata;
    assign bus.d_rdata     = bus.m_rdata;
    assign conflict_count  = r_conflict;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench: fixed-priority instance (u0) and round-robin instance with a 2-bit counter (u1).
module tb_cache_mem_arbiter;

    logic clk;
    logic rst_n;
    logic [31:0] cnt0;
    logic [1:0]  cnt1;
    int n_cmp;
    int n_bad;

    cache_mem_arbiter_if #(.ADDR_W(32), .LINE_W(256)) b0 ();
    cache_mem_arbiter_if #(.ADDR_W(32), .LINE_W(256)) b1 ();

    cache_mem_arbiter #(.ADDR_W(32), .LINE_W(256), .RR_EN(0), .CNT_W(32)) u0 (
        .clk(clk), .rst_n(rst_n), .bus(b0), .conflict_count(cnt0)
    );
    cache_mem_arbiter #(.ADDR_W(32), .LINE_W(256), .RR_EN(1), .CNT_W(2)) u1 (
        .clk(clk), .rst_n(rst_n), .bus(b1), .conflict_count(cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    logic [255:0] pat_a5;
    logic [255:0] pat_be;
    logic [255:0] pat_3c;

    initial begin
        n_cmp = 0;
        n_bad = 0;
        pat_a5 = {32{8'hA5}};
        pat_be = {8{32'hDEAD_BEEF}};
        pat_3c = {32{8'h3C}};
        {b0.i_read, b0.d_read, b0.d_write, b0.m_resp} = '0;
        {b1.i_read, b1.d_read, b1.d_write, b1.m_resp} = '0;
        b0.i_addr = '0; b0.d_addr = '0; b0.d_wdata = '0; b0.m_rdata = '0;
        b1.i_addr = '0; b1.d_addr = '0; b1.d_wdata = '0; b1.m_rdata = '0;

        // reset state
        rst_n = 1'b0;
        repeat (3) cyc();
        chk("rst_m_read", b0.m_read, 0);
        chk("rst_m_write", b0.m_write, 0);
        chk("rst_cnt", cnt0, 0);
        rst_n = 1'b1;
        cyc();

        // 1: single icache read, spurious m_resp in RELEASE and IDLE
        b0.i_read = 1'b1; b0.i_addr = 32'h60;
        cyc();
        chk("t1_m_read", b0.m_read, 1);
        chk("t1_m_addr", b0.m_addr, 32'h60);
        chk("t1_m_write", b0.m_write, 0);
        chk("t1_i_resp_early", b0.i_resp, 0);
        cyc(); cyc();
        chk("t1_m_read_held", b0.m_read, 1);
        b0.m_resp = 1'b1; b0.m_rdata = pat_a5;
        #1;
        chk("t1_i_resp", b0.i_resp, 1);
        chk("t1_i_rdata", b0.i_rdata, pat_a5);
        chk("t1_d_resp", b0.d_resp, 0);
        cyc();
        b0.i_read = 1'b0;
        #1;
        chk("t1_rel_i_resp", b0.i_resp, 0);
        chk("t1_rel_m_read", b0.m_read, 0);
        chk("t1_rel_m_addr", b0.m_addr, 0);
        b0.m_resp = 1'b0;
        cyc();
        b0.m_resp = 1'b1;
        #1;
        chk("t6_idle_i_resp", b0.i_resp, 0);
        chk("t6_idle_d_resp", b0.d_resp, 0);
        b0.m_resp = 1'b0;
        cyc();
        chk("t6_idle_stays", b0.m_read, 0);

        // 2: fixed priority conflict, dcache first then icache
        b0.i_read = 1'b1; b0.i_addr = 32'h100;
        b0.d_read = 1'b1; b0.d_addr = 32'h200;
        cyc();
        chk("t2_d_addr", b0.m_addr, 32'h200);
        chk("t2_d_m_read", b0.m_read, 1);
        chk("t2_cnt", cnt0, 1);
        b0.m_resp = 1'b1; b0.m_rdata = pat_3c;
        #1;
        chk("t2_d_resp", b0.d_resp, 1);
        chk("t2_d_rdata", b0.d_rdata, pat_3c);
        chk("t2_no_i_resp", b0.i_resp, 0);
        cyc();
        b0.d_read = 1'b0; b0.m_resp = 1'b0;
        chk("t2_rel_m_read", b0.m_read, 0);
        cyc();
        chk("t2_idle_m_read", b0.m_read, 0);
        cyc();
        chk("t2_i_addr", b0.m_addr, 32'h100);
        chk("t2_cnt_after", cnt0, 1);
        b0.m_resp = 1'b1;
        #1;
        chk("t2_i_resp", b0.i_resp, 1);
        cyc();
        b0.i_read = 1'b0; b0.m_resp = 1'b0;
        cyc();

        // 4: write-back wins over a simultaneous read flag
        b0.d_write = 1'b1; b0.d_read = 1'b1;
        b0.d_addr = 32'h1000; b0.d_wdata = pat_be;
        cyc();
        chk("t4_m_write", b0.m_write, 1);
        chk("t4_m_read", b0.m_read, 0);
        chk("t4_m_addr", b0.m_addr, 32'h1000);
        chk("t4_m_wdata", b0.m_wdata, pat_be);
        b0.m_resp = 1'b1;
        #1;
        chk("t4_d_resp", b0.d_resp, 1);
        cyc();
        b0.d_write = 1'b0; b0.d_read = 1'b0; b0.m_resp = 1'b0;
        cyc();

        // 5: reset mid BUSY_D with icache pending, then re-arbitration
        b0.d_write = 1'b1; b0.d_addr = 32'h2000;
        b0.i_read = 1'b1; b0.i_addr = 32'h300;
        cyc();
        chk("t5_pre_m_write", b0.m_write, 1);
        chk("t5_pre_cnt", cnt0, 2);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_m_write", b0.m_write, 0);
        chk("t5_rst_m_read", b0.m_read, 0);
        chk("t5_rst_cnt", cnt0, 0);
        cyc();
        rst_n = 1'b1;
        cyc();
        chk("t5_regrant_d", b0.m_write, 1);
        chk("t5_regrant_addr", b0.m_addr, 32'h2000);
        chk("t5_cnt", cnt0, 1);
        b0.m_resp = 1'b1;
        cyc();
        b0.d_write = 1'b0; b0.m_resp = 1'b0;
        cyc();
        cyc();
        chk("t5_then_i", b0.m_addr, 32'h300);
        b0.m_resp = 1'b1;
        cyc();
        b0.i_read = 1'b0; b0.m_resp = 1'b0;
        cyc();

        // 3: round-robin with both held: D,I,D,I; 2-bit counter saturates at 3
        b1.i_read = 1'b1; b1.i_addr = 32'h40;
        b1.d_read = 1'b1; b1.d_addr = 32'h80;
        for (int g = 0; g < 4; g++) begin
            cyc();
            chk($sformatf("t3_grant%0d_addr", g), b1.m_addr, (g % 2 == 0) ? 32'h80 : 32'h40);
            b1.m_resp = 1'b1;
            #1;
            chk($sformatf("t3_grant%0d_i_resp", g), b1.i_resp, (g % 2 == 1) ? 1 : 0);
            chk($sformatf("t3_grant%0d_d_resp", g), b1.d_resp, (g % 2 == 0) ? 1 : 0);
            cyc();
            b1.m_resp = 1'b0;
            cyc();
            if (g == 2) chk("t3_cnt3", cnt1, 3);
        end
        chk("t3_cnt_sat", cnt1, 3);
        b1.i_read = 1'b0; b1.d_read = 1'b0;
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
